// File: rtl/bsg_age_stamp_buffer_if.sv
// Request/grant bundle between the per-input producers, the age arbiter and the stamp buffer.
// The buffer side uses the slave modport.
interface bsg_age_stamp_buffer_if #(
  parameter int inputs_p   = 4,
  parameter int width_p    = 32,
  parameter int ts_width_p = 8
);
  logic [inputs_p-1:0]                 v_i;
  logic [inputs_p-1:0][width_p-1:0]    data_i;
  logic [inputs_p-1:0]                 ready_o;
  logic [inputs_p-1:0]                 reqs_o;
  logic [inputs_p-1:0][ts_width_p-1:0] ts_o;
  logic [inputs_p-1:0]                 grants_i;
  logic                                v_o;
  logic [width_p-1:0]                  data_o;

  modport slave (
    input  v_i, data_i, grants_i,
    output ready_o, reqs_o, ts_o, v_o, data_o
  );

  modport master (
    output v_i, data_i, grants_i,
    input  ready_o, reqs_o, ts_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_age_stamp_buffer.sv
// Per-input FIFOs that stamp each accepted request with an arrival counter so the
// downstream age arbiter can grant the oldest head; the grant pops and forwards it.
module bsg_age_stamp_buffer #(
  parameter int inputs_p   = 4,
  parameter int width_p    = 32,
  parameter int els_p      = 2,
  parameter int ts_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bsg_age_stamp_buffer_if.slave   io
);

  localparam int ptr_w = $clog2(els_p);

  logic [width_p-1:0]    data_mem [inputs_p][els_p];
  logic [ts_width_p-1:0] ts_mem   [inputs_p][els_p];
  logic [ptr_w:0]        wptr     [inputs_p];
  logic [ptr_w:0]        rptr     [inputs_p];
  logic [ptr_w:0]        cnt      [inputs_p];
  logic [inputs_p-1:0]   empty, full, last, enq, deq;
  logic [ts_width_p-1:0] ctr;
  logic                  all_empty_next;

  function automatic logic [ts_width_p-1:0] sat_inc(input logic [ts_width_p-1:0] v);
    return (&v) ? v : v + ts_width_p'(1);
  endfunction

  // Occupancy from wrap pointers carrying one extra lap bit.
  always_comb begin
    for (int i = 0; i < inputs_p; i++) begin
      cnt[i]   = wptr[i] - rptr[i];
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][ptr_w] != rptr[i][ptr_w]) &&
                 (wptr[i][ptr_w-1:0] == rptr[i][ptr_w-1:0]);
      last[i]  = (cnt[i] == (ptr_w+1)'(1));
    end
  end

  always_comb begin
    io.data_o = '0;
    for (int i = 0; i < inputs_p; i++) begin
      io.ready_o[i] = ~full[i] & ~reset_i;
      io.reqs_o[i]  = ~empty[i] & ~reset_i;
      io.ts_o[i]    = io.reqs_o[i] ? ts_mem[i][rptr[i][ptr_w-1:0]] : '0;
      if (io.grants_i[i])
        io.data_o = io.data_o | data_mem[i][rptr[i][ptr_w-1:0]];
    end
    io.v_o = |io.grants_i;
  end

  assign enq = io.v_i & io.ready_o;
  assign deq = io.grants_i & io.reqs_o;
  assign all_empty_next = &(empty | (deq & last));

  // Control state: pointers and the shared stamp counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < inputs_p; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      ctr <= '0;
    end else begin
      for (int i = 0; i < inputs_p; i++) begin
        if (enq[i]) wptr[i] <= wptr[i] + (ptr_w+1)'(1);
        if (deq[i]) rptr[i] <= rptr[i] + (ptr_w+1)'(1);
      end
      if (|enq)
        ctr <= sat_inc(ctr);
      else if (all_empty_next)
        ctr <= '0;
    end
  end

  // Storage: every input accepted this cycle shares the current stamp.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < inputs_p; i++) begin
      if (enq[i]) begin
        data_mem[i][wptr[i][ptr_w-1:0]] <= io.data_i[i];
        ts_mem[i][wptr[i][ptr_w-1:0]]   <= ctr;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert ($onehot0(io.grants_i))
      else $error("bsg_age_stamp_buffer: grants_i not one-hot: %b", io.grants_i);
    assert ((io.grants_i & ~io.reqs_o) == '0)
      else $error("bsg_age_stamp_buffer: grant to empty input: %b", io.grants_i);
    assert (!(reset_i && (|io.v_i)))
      else $error("bsg_age_stamp_buffer: v_i asserted during reset: %b", io.v_i);
  end
`endif

endmodule

// File: tb/tb_bsg_age_stamp_buffer.sv
// Directed scoreboard bench: two buffers (default sizing, and a 2-bit stamp / depth-8 copy)
// fronted by a small age-arbiter model; a monitor pops expected {payload, stamp} on each grant.
module tb_bsg_age_stamp_buffer;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  ts;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ds_a, ds_b;
  int   total = 0;
  int   bad   = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [3:0][7:0] tsb_ext;

  always #5 clk = ~clk;

  bsg_age_stamp_buffer_if #(.inputs_p(4), .width_p(32), .ts_width_p(8)) ifa ();
  bsg_age_stamp_buffer_if #(.inputs_p(4), .width_p(32), .ts_width_p(2)) ifb ();

  bsg_age_stamp_buffer #(.inputs_p(4), .width_p(32), .els_p(2), .ts_width_p(8)) dut_a (
    .clk_i(clk), .reset_i(rst), .io(ifa)
  );
  bsg_age_stamp_buffer #(.inputs_p(4), .width_p(32), .els_p(8), .ts_width_p(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .io(ifb)
  );

  // Age arbiter model: smallest stamp wins, ties go to the higher index.
  function automatic logic [3:0] arb(input logic [3:0] r, input logic [3:0][7:0] ts);
    int best = -1;
    logic [3:0] g = '0;
    for (int i = 0; i < 4; i++)
      if (r[i] && (best < 0 || ts[i] <= ts[best])) best = i;
    if (best >= 0) g[best] = 1'b1;
    return g;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) tsb_ext[i] = {6'b0, ifb.ts_o[i]};
    ifa.grants_i = ds_a ? arb(ifa.reqs_o, ifa.ts_o) : 4'b0;
    ifb.grants_i = ds_b ? arb(ifb.reqs_o, tsb_ext) : 4'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Monitors: compare every forwarded transfer against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    int k;
    chk("v_o_a", {31'b0, ifa.v_o}, {31'b0, |ifa.grants_i});
    if (ifa.grants_i != 4'b0) begin
      k = idx_of(ifa.grants_i);
      if (qa.size() == 0) begin
        chk("unexpected_grant_a", ifa.data_o, 32'hDEAD_BEEF);
      end else begin
        e = qa.pop_front();
        chk("data_o_a", ifa.data_o, e.d);
        chk("stamp_a", {24'b0, ifa.ts_o[k]}, {24'b0, e.ts});
      end
    end else begin
      chk("data_o_idle_a", ifa.data_o, 32'h0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int k;
    chk("v_o_b", {31'b0, ifb.v_o}, {31'b0, |ifb.grants_i});
    if (ifb.grants_i != 4'b0) begin
      k = idx_of(ifb.grants_i);
      if (qb.size() == 0) begin
        chk("unexpected_grant_b", ifb.data_o, 32'hDEAD_BEEF);
      end else begin
        e = qb.pop_front();
        chk("data_o_b", ifb.data_o, e.d);
        chk("stamp_b", {24'b0, tsb_ext[k]}, {24'b0, e.ts});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a;
    int n = 0;
    while (qa.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_a_left", qa.size(), 0);
  endtask

  task automatic drain_b;
    int n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_b_left", qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ds_a = 1'b0;
    ds_b = 1'b0;
    ifa.v_i = '0;
    ifa.data_i = '0;
    ifb.v_i = '0;
    ifb.data_i = '0;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_ready_a", {28'b0, ifa.ready_o}, 32'h0);
    chk("rst_reqs_a", {28'b0, ifa.reqs_o}, 32'h0);
    chk("rst_ts_a", ifa.ts_o, 32'h0);
    chk("rst_ready_b", {28'b0, ifb.ready_o}, 32'h0);
    tick;
    rst = 1'b0;
    tick;

    // Single request, downstream ready: forwarded the cycle after enqueue.
    ds_a = 1'b1;
    qa.push_back('{d: 32'hA, ts: 8'd0});
    ifa.v_i = 4'b0001;
    ifa.data_i[0] = 32'hA;
    tick;
    ifa.v_i = 4'b0000;
    @(negedge clk);
    chk("t1_reqs", {28'b0, ifa.reqs_o}, 32'h1);
    chk("t1_ts0", {24'b0, ifa.ts_o[0]}, 32'h0);
    tick;
    @(negedge clk);
    chk("t1_reqs_after", {28'b0, ifa.reqs_o}, 32'h0);
    tick;

    // Input 2 then input 0 on successive cycles: stamps 0 and 1.
    ds_a = 1'b0;
    qa.push_back('{d: 32'h22, ts: 8'd0});
    qa.push_back('{d: 32'h00, ts: 8'd1});
    ifa.v_i = 4'b0100;
    ifa.data_i[2] = 32'h22;
    tick;
    ifa.v_i = 4'b0001;
    ifa.data_i[0] = 32'h00;
    tick;
    ifa.v_i = 4'b0000;
    @(negedge clk);
    chk("t2_reqs", {28'b0, ifa.reqs_o}, 32'h5);
    chk("t2_ts2", {24'b0, ifa.ts_o[2]}, 32'h0);
    chk("t2_ts0", {24'b0, ifa.ts_o[0]}, 32'h1);
    ds_a = 1'b1;
    drain_a;

    // Same-cycle enqueue on inputs 1 and 3: equal stamps, higher index first.
    ds_a = 1'b0;
    qa.push_back('{d: 32'h33, ts: 8'd0});
    qa.push_back('{d: 32'h11, ts: 8'd0});
    ifa.v_i = 4'b1010;
    ifa.data_i[1] = 32'h11;
    ifa.data_i[3] = 32'h33;
    tick;
    ifa.v_i = 4'b0000;
    @(negedge clk);
    chk("t3_ts1", {24'b0, ifa.ts_o[1]}, 32'h0);
    chk("t3_ts3", {24'b0, ifa.ts_o[3]}, 32'h0);
    ds_a = 1'b1;
    drain_a;

    // Backpressure on input 0: full after two accepts, no bypass on dequeue.
    ds_a = 1'b0;
    qa.push_back('{d: 32'h40, ts: 8'd0});
    qa.push_back('{d: 32'h41, ts: 8'd1});
    ifa.v_i = 4'b0001;
    ifa.data_i[0] = 32'h40;
    tick;
    ifa.data_i[0] = 32'h41;
    @(negedge clk);
    chk("t4_ready_one", {31'b0, ifa.ready_o[0]}, 32'h1);
    tick;
    ifa.data_i[0] = 32'h42;
    @(negedge clk);
    chk("t4_ready_full", {31'b0, ifa.ready_o[0]}, 32'h0);
    tick;
    ds_a = 1'b1;
    @(negedge clk);
    chk("t4_ready_nobypass", {31'b0, ifa.ready_o[0]}, 32'h0);
    tick;
    ds_a = 1'b0;
    ifa.v_i = 4'b0000;
    @(negedge clk);
    chk("t4_ready_back", {31'b0, ifa.ready_o[0]}, 32'h1);
    chk("t4_head_ts", {24'b0, ifa.ts_o[0]}, 32'h1);
    ds_a = 1'b1;
    drain_a;

    // Stamp saturation with 2-bit stamps on the deep instance.
    ds_b = 1'b0;
    qb.push_back('{d: 32'h50, ts: 8'd0});
    qb.push_back('{d: 32'h60, ts: 8'd1});
    qb.push_back('{d: 32'h61, ts: 8'd2});
    qb.push_back('{d: 32'h62, ts: 8'd3});
    qb.push_back('{d: 32'h63, ts: 8'd3});
    qb.push_back('{d: 32'h64, ts: 8'd3});
    ifb.v_i = 4'b0001;
    ifb.data_i[0] = 32'h50;
    tick;
    ifb.v_i = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      ifb.data_i[1] = 32'h60 + k;
      tick;
    end
    ifb.v_i = 4'b0000;
    @(negedge clk);
    chk("t5_ts0", {24'b0, tsb_ext[0]}, 32'h0);
    chk("t5_ts1", {24'b0, tsb_ext[1]}, 32'h1);
    ds_b = 1'b1;
    drain_b;

    // Mid-operation reset discards buffered entries and rebases the stamp.
    ds_a = 1'b0;
    ifa.v_i = 4'b0011;
    ifa.data_i[0] = 32'h90;
    ifa.data_i[1] = 32'h91;
    tick;
    ifa.v_i = 4'b0001;
    ifa.data_i[0] = 32'h92;
    tick;
    ifa.v_i = 4'b0000;
    @(negedge clk);
    chk("t6_reqs_before", {28'b0, ifa.reqs_o}, 32'h3);
    tick;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", {28'b0, ifa.ready_o}, 32'h0);
    chk("t6_rst_reqs", {28'b0, ifa.reqs_o}, 32'h0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_reqs_after", {28'b0, ifa.reqs_o}, 32'h0);
    chk("t6_ready_after", {28'b0, ifa.ready_o}, 32'hF);
    qa.push_back('{d: 32'h77, ts: 8'd0});
    ifa.v_i = 4'b1000;
    ifa.data_i[3] = 32'h77;
    tick;
    ifa.v_i = 4'b0000;
    @(negedge clk);
    chk("t6_ts3", {24'b0, ifa.ts_o[3]}, 32'h0);
    ds_a = 1'b1;
    drain_a;

    repeat (3) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
